frv_lsu_mq: RTL

- Parametrised, multi-outstanding load/store unit for the memory stage.
- Accepts decoded load/store requests and checks alignment.
- Issues byte-laned requests on the dmem req/gnt bus.
- Tracks up to DEPTH in-flight transactions. Returns in-order, extracted and sign-extended responses to writeback.
- Adds a leakage-fence drain handshake and flush-safe discard of in-flight responses.

---
 rtl/frv_lsu_mq_pkg.sv | 37 +++
 rtl/frv_lsu_mq_extract.sv | 71 +++++++
 rtl/frv_lsu_mq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/frv_lsu_mq_pkg.sv
// Shared encodings and types for the multi-outstanding load/store unit.
package frv_lsu_mq_pkg;

  // Access size encodings carried on in_size.
  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

  // Fence drain handshake states.
  typedef enum logic [1:0] {
    FENCE_IDLE  = 2'd0,
    FENCE_DRAIN = 2'd1,
    FENCE_DONE  = 2'd2
  } fence_state_t;

  // Per-entry request metadata captured at push time.
  typedef struct packed {
    logic       load;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
    logic       mis;
  } mq_meta_t;

  // Halfwords need an even address, words a 4-byte aligned one; the
  // reserved size encoding is never issued to the bus.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
    case (size)
      LSU_SIZE_BYTE: return 1'b0;
      LSU_SIZE_HALF: return off[0];
      LSU_SIZE_WORD: return (off != 2'b00);
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/frv_lsu_mq_extract.sv
// Byte-lane placement for outgoing stores and lane extraction with
// sign/zero extension for returning loads. Purely combinational.
module frv_lsu_mq_extract
  import frv_lsu_mq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      iss_size,
  input  logic [1:0]      iss_off,
  input  logic [XLEN-1:0] iss_wdata,
  output logic [3:0]      iss_strb,
  output logic [XLEN-1:0] iss_wdata_lane,
  input  logic [1:0]      rsp_size,
  input  logic [1:0]      rsp_off,
  input  logic            rsp_signed,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic [XLEN-1:0] rsp_data
);

  function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b,
                                                input logic       sgn);
    logic signed [7:0]      sb;
    logic signed [XLEN-1:0] wide;
    sb   = b;
    wide = sb;
    if (sgn) return $unsigned(wide);
    return {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h,
                                                input logic        sgn);
    logic signed [15:0]     sh;
    logic signed [XLEN-1:0] wide;
    sh   = h;
    wide = sh;
    if (sgn) return $unsigned(wide);
    return {{(XLEN-16){1'b0}}, h};
  endfunction

  logic [XLEN-1:0] lane;

  // Store side: replicate the narrow datum into every lane, strobe the addressed ones.
  always_comb begin
    iss_strb       = 4'b0000;
    iss_wdata_lane = iss_wdata;
    case (iss_size)
      LSU_SIZE_BYTE: begin
        iss_strb       = 4'b0001 << iss_off;
        iss_wdata_lane = {4{iss_wdata[7:0]}};
      end
      LSU_SIZE_HALF: begin
        iss_strb       = iss_off[1] ? 4'b1100 : 4'b0011;
        iss_wdata_lane = {2{iss_wdata[15:0]}};
      end
      LSU_SIZE_WORD: iss_strb = 4'b1111;
      default:       iss_strb = 4'b0000;
    endcase
  end

  // Load side: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane     = rsp_rdata >> {rsp_off, 3'b000};
    rsp_data = lane;
    case (rsp_size)
      LSU_SIZE_BYTE: rsp_data = ext_byte(lane[7:0], rsp_signed);
      LSU_SIZE_HALF: rsp_data = ext_half(lane[15:0], rsp_signed);
      default:       rsp_data = lane;
    endcase
  end

endmodule

// File: rtl/frv_lsu_mq.sv
// Memory-stage load/store unit with an in-order tracker of up to DEPTH
// outstanding bus transactions, flush-safe response discarding and a
// fence drain handshake.
module frv_lsu_mq
  import frv_lsu_mq_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_signed,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            fence_req,
  output logic            fence_done,
  output logic            dmem_req,
  output logic            dmem_wen,
  output logic [3:0]      dmem_strb,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [XLEN-1:0] dmem_addr,
  input  logic            dmem_gnt,
  input  logic            dmem_recv,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_error,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_rdata_unused_guard,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic            rsp_misalign,
  output logic [PW:0]     outstanding
);

  // Drop counter has headroom for several flushes of a full tracker
  // landing before the bus has returned the abandoned beats.
  localparam int           DW       = PW + 4;
  localparam logic [PW:0]  FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]  PTR_ONE  = (PW+1)'(1);
  localparam logic [DW-1:0] DROP_ONE = DW'(1);

  logic [PW:0]      wr_ptr, rcv_ptr, rd_ptr;
  logic [DW-1:0]    drop;
  fence_state_t     fence_state;
  logic [DEPTH-1:0] done;
  logic [DEPTH-1:0] err;
  mq_meta_t         meta [DEPTH];
  logic [XLEN-1:0]  data [DEPTH];

  logic [PW-1:0]   wr_idx, rcv_idx, rd_idx;
  logic [1:0]      in_off;
  logic            in_mis, full, ok_to_accept;
  logic            push, push_mis, recv_write, pop;
  logic [3:0]      iss_strb;
  logic [XLEN-1:0] iss_wdata_lane, head_data;
  logic [PW:0]     pending;
  logic [DW-1:0]   drop_sum, drop_flush;
  mq_meta_t        head;

  assign wr_idx  = wr_ptr[PW-1:0];
  assign rcv_idx = rcv_ptr[PW-1:0];
  assign rd_idx  = rd_ptr[PW-1:0];

  assign outstanding = wr_ptr - rd_ptr;
  assign full        = (outstanding == FULL_CNT);

  assign in_off = in_addr[1:0];
  assign in_mis = lsu_misaligned(in_size, in_off);

  // Nothing is accepted in reset, while full, while a fence is in progress
  // or in the flush cycle.
  assign ok_to_accept = g_resetn && !full && (fence_state == FENCE_IDLE) && !flush;

  // Misaligned requests never reach the bus; they wait for an empty tracker
  // so their error entry cannot overtake older responses.
  assign dmem_req = in_valid && !in_mis && ok_to_accept;
  assign push_mis = in_valid && in_mis && ok_to_accept && (outstanding == '0);
  assign in_ready = (dmem_req && dmem_gnt) || push_mis;
  assign push     = in_ready;

  assign dmem_wen   = dmem_req && in_store;
  assign dmem_strb  = dmem_req ? iss_strb : 4'b0000;
  assign dmem_wdata = iss_wdata_lane;
  assign dmem_addr  = {in_addr[XLEN-1:2], 2'b00};

  // Beats owed to flushed entries are swallowed before any live entry is
  // written; a stray beat with nothing pending is ignored.
  assign recv_write = dmem_recv && (drop == '0) && !flush && (rcv_ptr != wr_ptr);

  assign head      = meta[rd_idx];
  assign head_data = data[rd_idx];
  assign rsp_valid = done[rd_idx];
  assign pop       = rsp_valid && rsp_ready;

  assign rsp_error    = rsp_valid && err[rd_idx];
  assign rsp_misalign = rsp_valid && head.mis;

  // Misaligned entries never get a recv, so wr - rcv counts only beats the
  // bus still owes; a beat landing in the flush cycle settles one of them.
  assign pending    = wr_ptr - rcv_ptr;
  assign drop_sum   = drop + DW'(pending);
  assign drop_flush = (dmem_recv && (drop_sum != '0)) ? drop_sum - DROP_ONE : drop_sum;

  logic [XLEN-1:0] ext_data;

  frv_lsu_mq_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .iss_size       (in_size),
    .iss_off        (in_off),
    .iss_wdata      (in_wdata),
    .iss_strb       (iss_strb),
    .iss_wdata_lane (iss_wdata_lane),
    .rsp_size       (head.size),
    .rsp_off        (head.off),
    .rsp_signed     (head.sgn),
    .rsp_rdata      (head_data),
    .rsp_data       (ext_data)
  );

  assign rsp_rdata = (rsp_valid && head.load && !head.mis) ? ext_data : '0;
  assign rsp_rdata_unused_guard = 1'b0;

  // Tracker control: pointers, done bits and the flush drop counter.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wr_ptr  <= '0;
      rcv_ptr <= '0;
      rd_ptr  <= '0;
      done    <= '0;
      drop    <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rcv_ptr <= '0;
      rd_ptr  <= '0;
      done    <= '0;
      drop    <= drop_flush;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + PTR_ONE;
        done[wr_idx]   <= push_mis;
        if (push_mis) rcv_ptr <= rcv_ptr + PTR_ONE;
      end
      if (recv_write) begin
        done[rcv_idx] <= 1'b1;
        rcv_ptr       <= rcv_ptr + PTR_ONE;
      end
      if (dmem_recv && (drop != '0)) drop <= drop - DROP_ONE;
      if (pop) begin
        done[rd_idx] <= 1'b0;
        rd_ptr       <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Tracker payload: request metadata on push, bus data and error on receive.
  always_ff @(posedge g_clk) begin
    if (push) begin
      meta[wr_idx] <= '{load: in_load, size: in_size, sgn: in_signed,
                        off: in_off, mis: push_mis};
      err[wr_idx]  <= 1'b0;
    end
    if (recv_write) begin
      data[rcv_idx] <= dmem_rdata;
      err[rcv_idx]  <= dmem_error;
    end
  end

  // Fence drain handshake; flush does not disturb it, so a drain also
  // waits for every abandoned beat to come back.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      fence_state <= FENCE_IDLE;
      fence_done  <= 1'b0;
    end else begin
      fence_done <= 1'b0;
      case (fence_state)
        FENCE_IDLE:  if (fence_req) fence_state <= FENCE_DRAIN;
        FENCE_DRAIN: if ((outstanding == '0) && (drop == '0)) begin
          fence_state <= FENCE_DONE;
          fence_done  <= 1'b1;
        end
        FENCE_DONE:  fence_state <= FENCE_IDLE;
        default:     fence_state <= FENCE_IDLE;
      endcase
    end
  end

endmodule
